// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer: owns PC, IR and the Z/C flags and
// steers the datapath and the instruction/data memory handshakes from state+IR.
module control_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [7:0]      dmem_addr,
    output logic [7:0]      dmem_wdata,
    input  logic            dmem_ack,
    input  logic [7:0]      read_a,
    input  logic [7:0]      read_b,
    input  logic            alu_zero,
    input  logic            alu_carry,
    output logic            write_alu,
    output logic            is_load,
    output logic            write_en,
    output logic            imm_flag,
    output logic [2:0]      alu_opcode,
    output logic [7:0]      imm_data,
    output logic [3:0]      write_addr,
    output logic [3:0]      ra_addr,
    output logic [3:0]      rb_addr,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'b1000;
    localparam logic [3:0] OP_LD   = 4'b1001;
    localparam logic [3:0] OP_ST   = 4'b1010;
    localparam logic [3:0] OP_ADDI = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_BZ   = 4'b1101;
    localparam logic [3:0] OP_BC   = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic            z_q, z_d;
    logic            c_q, c_d;

    logic [3:0]      op;
    logic            op_alu;
    logic            op_addi;
    logic            op_ldi;
    logic            op_ld;
    logic            op_st;
    logic [PC_W-1:0] target;

    assign op      = ir_q[15:12];
    assign op_alu  = ~op[3];
    assign op_addi = (op == OP_ADDI);
    assign op_ldi  = (op == OP_LDI);
    assign op_ld   = (op == OP_LD);
    assign op_st   = (op == OP_ST);
    assign target  = PC_W'(ir_q[7:0]);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        z_d     = z_q;
        c_d     = c_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (op_alu || op_addi) begin
                    z_d = alu_zero;
                    c_d = alu_carry;
                end else begin
                    // Branches test the flags as they stood before this EXEC cycle
                    case (op)
                        OP_LD, OP_ST: state_d = S_MEM;
                        OP_JMP:       pc_d = target;
                        OP_BZ:        if (z_q) pc_d = target;
                        OP_BC:        if (c_q) pc_d = target;
                        OP_HALT:      state_d = S_HALT;
                        default:      ;
                    endcase
                end
            end
            S_MEM:  if (dmem_ack) state_d = S_FETCH;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    logic in_exec;
    logic in_mem;
    assign in_exec = (state_q == S_EXEC);
    assign in_mem  = (state_q == S_MEM);

    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign dmem_req   = in_mem;
    assign dmem_we    = in_mem && op_st;
    assign dmem_addr  = read_a;
    assign dmem_wdata = read_b;

    // Load write-back happens in the ack cycle, while RAM data is valid
    assign write_alu  = in_exec && (op_alu || op_addi);
    assign is_load    = in_mem && op_ld && dmem_ack;
    assign write_en   = (in_exec && (op_alu || op_addi || op_ldi)) || is_load;

    assign imm_flag   = op_addi;
    assign alu_opcode = op_alu ? ir_q[14:12] : 3'b000;
    assign imm_data   = ir_q[7:0];
    assign write_addr = ir_q[11:8];
    assign ra_addr    = op_addi ? ir_q[11:8] : ir_q[7:4];
    assign rb_addr    = ir_q[3:0];
    assign halted     = (state_q == S_HALT);

endmodule
